// File: rtl/parity_bus_master.sv
// Master-side controller for the parity-protected main bus.
// Issues single reads and writes, checks read parity, and retries after a parity error or timeout.
module parity_bus_master #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ADDR_BUS_WIDTH = 8,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRIES    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [ADDR_BUS_WIDTH-1:0] req_addr,
  input  logic [DATA_BUS_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [1:0]                rsp_status,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_BUS_WIDTH-1:0] address,
  output logic [DATA_BUS_WIDTH-1:0] data_out,
  output logic                      data_oe,
  output logic                      parity_out,
  input  logic [DATA_BUS_WIDTH-1:0] data_in,
  input  logic                      parity_in,
  output logic                      RB,
  output logic                      WB,
  input  logic                      ack
);

  // state    | meaning
  // IDLE     | ready for a request, strobes low
  // WAIT_ACK | RB or WB high, waiting for the slave to raise ack
  // ACK_LOW  | strobes low, waiting for ack to fall, then retry or respond
  typedef enum logic [1:0] {IDLE, WAIT_ACK, ACK_LOW} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] RETRY_MAX  = CW'(MAX_RETRIES);
  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_PERR = 2'b01;
  localparam logic [1:0] ST_TMO  = 2'b10;

  state_t                    state_q, state_d;
  logic                      rw_q, rw_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_BUS_WIDTH-1:0] rbuf_q, rbuf_d;
  logic [1:0]                err_q, err_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [CW-1:0]             retry_q, retry_d;
  logic [ADDR_BUS_WIDTH-1:0] address_d;
  logic [DATA_BUS_WIDTH-1:0] data_out_d, rsp_rdata_d;
  logic                      data_oe_d, parity_out_d, rb_d, wb_d, rsp_valid_d;
  logic [1:0]                rsp_status_d;
  logic                      issue, issue_rw, done;
  logic [DATA_BUS_WIDTH-1:0] issue_wdata;
  logic [1:0]                final_err;

  assign req_ready = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rbuf_d       = rbuf_q;
    err_d        = err_q;
    timer_d      = timer_q;
    retry_d      = retry_q;
    address_d    = address;
    data_out_d   = data_out;
    data_oe_d    = data_oe;
    parity_out_d = parity_out;
    rb_d         = RB;
    wb_d         = WB;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status;
    rsp_rdata_d  = rsp_rdata;
    issue        = 1'b0;
    issue_rw     = rw_q;
    issue_wdata  = wdata_q;
    done         = 1'b0;
    final_err    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d        = req_rw;
          address_d   = req_addr;
          wdata_d     = req_wdata;
          retry_d     = '0;
          issue       = 1'b1;
          issue_rw    = req_rw;
          issue_wdata = req_wdata;
        end
      end
      WAIT_ACK: begin
        if (ack) begin
          rb_d         = 1'b0;
          wb_d         = 1'b0;
          data_oe_d    = 1'b0;
          parity_out_d = 1'b0;
          timer_d      = '0;
          state_d      = ACK_LOW;
          if (!rw_q) begin
            rbuf_d = data_in;
            err_d  = ((^data_in) != parity_in) ? ST_PERR : ST_OK;
          end
        end else if (timer_q == TIMER_LAST) begin
          rb_d         = 1'b0;
          wb_d         = 1'b0;
          data_oe_d    = 1'b0;
          parity_out_d = 1'b0;
          timer_d      = '0;
          err_d        = ST_TMO;
          state_d      = ACK_LOW;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ACK_LOW: begin
        if (!ack) begin
          done = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          done      = 1'b1;
          final_err = ST_TMO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
        if (done) begin
          if (final_err != ST_OK && retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            issue   = 1'b1;
          end else begin
            state_d      = IDLE;
            rsp_valid_d  = 1'b1;
            rsp_status_d = final_err;
            rsp_rdata_d  = (!rw_q && final_err == ST_OK) ? rbuf_q : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A retry re-drives from the latched request; the ACK_LOW cycle is the strobe-low gap.
    if (issue) begin
      state_d      = WAIT_ACK;
      timer_d      = '0;
      err_d        = ST_OK;
      rb_d         = !issue_rw;
      wb_d         = issue_rw;
      data_oe_d    = issue_rw;
      parity_out_d = issue_rw & (^issue_wdata);
      if (issue_rw) data_out_d = issue_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      err_q      <= ST_OK;
      timer_q    <= '0;
      retry_q    <= '0;
      address    <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      parity_out <= 1'b0;
      RB         <= 1'b0;
      WB         <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      address    <= address_d;
      data_out   <= data_out_d;
      data_oe    <= data_oe_d;
      parity_out <= parity_out_d;
      RB         <= rb_d;
      WB         <= wb_d;
      rsp_valid  <= rsp_valid_d;
      rsp_status <= rsp_status_d;
      rsp_rdata  <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_parity_bus_master.sv
// Bench for parity_bus_master: scripted bus slave, transaction-level reference model,
// directed scenarios followed by randomized transactions.
module tb_parity_bus_master;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 16;
  localparam int MR = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out, data_in;
  logic          data_oe, parity_out, parity_in, RB, WB, ack;

  always #5 clock = ~clock;

  parity_bus_master #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW),
                      .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
    .address(address), .data_out(data_out), .data_oe(data_oe), .parity_out(parity_out),
    .data_in(data_in), .parity_in(parity_in), .RB(RB), .WB(WB), .ack(ack)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-attempt slave script: ack delay (>=TO means never), ack hold, bad parity, read data.
  int          d_a[4];
  int          h_a[4];
  bit          bad_a[4];
  logic [31:0] rd_a[4];
  int          att, hi_cnt, hold;
  bit          prev_str;

  always @(negedge clock) begin
    if (RB || WB) begin
      if (!ack && att < 3) begin
        hi_cnt++;
        if (hi_cnt > d_a[att]) begin
          ack       = 1'b1;
          data_in   = rd_a[att];
          parity_in = (^rd_a[att]) ^ bad_a[att];
          hold      = 0;
        end
      end
    end else begin
      if (prev_str && !ack) att++;
      hi_cnt = 0;
      if (ack) begin
        if (hold >= h_a[att]) begin
          ack = 1'b0;
          att++;
        end else begin
          hold++;
        end
      end
    end
    prev_str = RB || WB;
  end

  int          widths[$];
  int          cur_w   = 0;
  int          bad_drv = 0;
  int          rsp_cnt = 0;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;

  always @(negedge clock) begin
    if (rsp_valid) rsp_cnt++;
    if (RB || WB) begin
      cur_w++;
      if (address !== exp_addr) bad_drv++;
      if (RB && WB) bad_drv++;
      if (WB && (data_oe !== 1'b1 || data_out !== exp_wdata || parity_out !== ^exp_wdata)) bad_drv++;
      if (RB && data_oe !== 1'b0) bad_drv++;
    end else begin
      if (data_oe !== 1'b0) bad_drv++;
      if (cur_w > 0) begin
        widths.push_back(cur_w);
        cur_w = 0;
      end
    end
  end

  // Transaction-level outcome: attempts until success or retries exhausted.
  function automatic void model(input bit rw, output int n_att, output logic [1:0] st,
                                output logic [31:0] rdata, output int lat);
    n_att = 0;
    st    = 2'b00;
    lat   = 0;
    for (int a = 0; a <= MR; a++) begin
      n_att = a + 1;
      if (d_a[a] >= TO) begin
        st  = 2'b10;
        lat = lat + TO + 1;
      end else begin
        st  = (!rw && bad_a[a]) ? 2'b01 : 2'b00;
        lat = lat + d_a[a] + 1 + h_a[a] + 1;
      end
      if (st == 2'b00) break;
    end
    rdata = (!rw && st == 2'b00) ? rd_a[n_att-1] : 32'h0;
  endfunction

  task automatic set_att(input int i, input int d, input int h, input bit bad, input logic [31:0] rd);
    d_a[i] = d; h_a[i] = h; bad_a[i] = bad; rd_a[i] = rd;
  endtask

  task automatic do_txn(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input bit b2b, input string tag);
    int n_att, lat, cyc;
    logic [1:0] st;
    logic [31:0] rdx;
    bit got;
    model(rw, n_att, st, rdx, lat);
    att = 0; hi_cnt = 0; hold = 0;
    widths.delete();
    bad_drv   = 0;
    exp_addr  = a;
    exp_wdata = wd;
    chk({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_rw = rw; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
    cyc = 0;
    got = 0;
    while (!got && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk({tag, ".strobe"}, rw ? WB : RB, 1);
        chk({tag, ".busy"}, req_ready, 0);
        if (rw) chk({tag, ".parity_out"}, parity_out, ^wd);
      end
      if (rsp_valid) got = 1;
    end
    chk({tag, ".rsp_seen"}, got, 1);
    chk({tag, ".latency"}, cyc - 1, lat);
    chk({tag, ".status"}, rsp_status, st);
    chk({tag, ".rdata"}, rsp_rdata, rdx);
    chk({tag, ".pulses"}, widths.size(), n_att);
    for (int i = 0; i < n_att && i < widths.size(); i++)
      chk({tag, ".width"}, widths[i], (d_a[i] >= TO) ? TO : d_a[i] + 1);
    chk({tag, ".drive"}, bad_drv, 0);
    n_txn++;
    if (!b2b) begin
      @(negedge clock);
      chk({tag, ".rsp_one_cycle"}, rsp_valid, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int r;
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    ack = 1'b0; data_in = '0; parity_in = 1'b0;
    att = 0; hi_cnt = 0; hold = 0; prev_str = 0;
    exp_addr = '0; exp_wdata = '0;
    for (int i = 0; i < 4; i++) set_att(i, 0, 0, 0, 32'h0);
    repeat (3) @(negedge clock);
    chk("rst.RB", RB, 0);
    chk("rst.WB", WB, 0);
    chk("rst.data_oe", data_oe, 0);
    chk("rst.parity_out", parity_out, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.address", address, 0);
    chk("rst.data_out", data_out, 0);
    chk("rst.rsp_rdata", rsp_rdata, 0);
    chk("rst.rsp_status", rsp_status, 0);
    chk("rst.req_ready", req_ready, 1);
    reset = 1'b0;
    ack = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_ack.ready", req_ready, 1);
    chk("idle_ack.rsp", rsp_cnt, 0);
    ack = 1'b0;
    @(negedge clock);

    set_att(0, 2, 0, 0, 32'h0);
    do_txn(1'b1, 8'h01, 32'h0000_0001, 0, "wr_basic");
    set_att(0, 1, 1, 0, 32'hA5A5_0003);
    do_txn(1'b0, 8'h02, 32'h0, 0, "rd_basic");
    for (int i = 0; i < 3; i++) set_att(i, 1, 0, 1, 32'h1234_5678 + i);
    do_txn(1'b0, 8'h03, 32'h0, 0, "rd_perr_all");
    for (int i = 0; i < 3; i++) set_att(i, 100, 0, 0, 32'h0);
    do_txn(1'b1, 8'h04, 32'hDEAD_BEEF, 0, "wr_timeout");
    set_att(0, 0, 0, 1, 32'h1111_1111);
    set_att(1, 3, 2, 0, 32'h2222_2223);
    do_txn(1'b0, 8'h05, 32'h0, 0, "rd_perr_then_ok");
    set_att(0, TO - 1, 0, 0, 32'h0);
    do_txn(1'b1, 8'h06, 32'h0000_0003, 0, "wr_ack_last_cycle");
    set_att(0, TO, 0, 0, 32'h0);
    set_att(1, 0, 0, 0, 32'h0);
    do_txn(1'b1, 8'h07, 32'h0F0F_0001, 0, "wr_ack_too_late");
    set_att(0, 0, 0, 0, 32'h0);
    do_txn(1'b1, 8'h08, 32'h0000_00FF, 1, "b2b_first");
    set_att(0, 0, 0, 0, 32'hCAFE_0001);
    do_txn(1'b0, 8'h09, 32'h0, 0, "b2b_second");

    for (int i = 0; i < 3; i++) set_att(i, 100, 0, 0, 32'h0);
    att = 0; hi_cnt = 0; hold = 0; exp_addr = 8'h0A;
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h0A;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    chk("midrst.RB_before", RB, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst.RB", RB, 0);
    chk("midrst.WB", WB, 0);
    chk("midrst.ready", req_ready, 1);
    chk("midrst.rsp_valid", rsp_valid, 0);
    r = rsp_cnt;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("midrst.no_rsp", rsp_cnt, r);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 3; i++)
        set_att(i, ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 4),
                $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
      do_txn($urandom_range(0, 1), AW'($urandom), $urandom, $urandom_range(0, 1), "rand");
    end
    @(negedge clock);
    chk("rsp_pulse_total", rsp_cnt, n_txn);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
